// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcodes, descriptor kinds and field widths.
// Used by the control decoder, the stream encoder and the assembler bench.
package mips_isa_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned TARGET_W = 26;
    localparam int unsigned KIND_W   = 3;

    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_ITYPE = 6'b000001;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [KIND_W-1:0] {
        KindLw    = 3'd0,
        KindSw    = 3'd1,
        KindRtype = 3'd2,
        KindItype = 3'd3,
        KindJump  = 3'd4
    } instr_kind_t;

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Handshaked instruction-descriptor stream: the source drives the master side,
// the encoder consumes on the slave side.
interface instr_stream_encoder_if;

    logic                                 in_valid;
    logic                                 in_ready;
    logic [mips_isa_pkg::KIND_W-1:0]      in_kind;
    logic [mips_isa_pkg::REG_W-1:0]       in_rs;
    logic [mips_isa_pkg::REG_W-1:0]       in_rt;
    logic [mips_isa_pkg::REG_W-1:0]       in_rd;
    logic [mips_isa_pkg::FUNCT_W-1:0]     in_funct;
    logic [mips_isa_pkg::IMM_W-1:0]       in_imm;
    logic [mips_isa_pkg::TARGET_W-1:0]    in_target;
    logic                                 in_last;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
        output in_ready
    );

endinterface

// File: rtl/instr_word_encode.sv
// Combinational descriptor-to-word encoder; kinds outside the enum are flagged
// illegal and produce an all-zero word.
module instr_word_encode
    import mips_isa_pkg::*;
(
    input  logic [KIND_W-1:0]   kind,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic [IMM_W-1:0]    imm,
    input  logic [TARGET_W-1:0] target,
    output logic [WORD_W-1:0]   word,
    output logic                legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (kind)
            KindLw:    word = {OP_LW, rs, rt, imm};
            KindSw:    word = {OP_SW, rs, rt, imm};
            KindItype: word = {OP_ITYPE, rs, rt, imm};
            // shamt is never produced by this source, so it is tied to zero
            KindRtype: word = {OP_RTYPE, rs, rt, rd, {SHAMT_W{1'b0}}, funct};
            KindJump:  word = {OP_J, target};
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Encodes a descriptor stream into MIPS words and writes them sequentially into
// instruction memory from a programmable base address.
module instr_stream_encoder
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    instr_stream_encoder_if.slave inIf,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [WORD_W-1:0]     imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err_kind,
    output logic                  err_full,
    output logic [ADDR_W:0]       count
);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} encState_e;

    localparam logic [ADDR_W-1:0] TopAddr = '1;

    encState_e         stateQ;
    logic [ADDR_W-1:0] ptrQ;
    logic [ADDR_W:0]   countQ;
    logic              weQ;
    logic [WORD_W-1:0] wdataQ;
    logic              errKindQ;
    logic              errFullQ;

    logic              accept;
    logic [ADDR_W-1:0] wrAddr;
    logic              topHit;
    logic [WORD_W-1:0] encWord;
    logic              encLegal;

    instr_word_encode uEncode (
        .kind   (inIf.in_kind),
        .rs     (inIf.in_rs),
        .rt     (inIf.in_rt),
        .rd     (inIf.in_rd),
        .funct  (inIf.in_funct),
        .imm    (inIf.in_imm),
        .target (inIf.in_target),
        .word   (encWord),
        .legal  (encLegal)
    );

    // ptr only advances once the previous write retires, so a descriptor accepted
    // while a write is pending lands one word further on.
    always_comb begin
        accept = (stateQ == StLoad) && inIf.in_valid;
        wrAddr = weQ ? ptrQ + 1'b1 : ptrQ;
        topHit = (wrAddr == TopAddr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= StIdle;
            ptrQ     <= '0;
            countQ   <= '0;
            weQ      <= 1'b0;
            wdataQ   <= '0;
            errKindQ <= 1'b0;
            errFullQ <= 1'b0;
        end else begin
            weQ <= 1'b0;
            if (weQ) begin
                countQ <= countQ + 1'b1;
                if (ptrQ != TopAddr) begin
                    ptrQ <= ptrQ + 1'b1;
                end
            end
            case (stateQ)
                StIdle, StDone: begin
                    if (start) begin
                        stateQ   <= StLoad;
                        ptrQ     <= base_addr;
                        countQ   <= '0;
                        errKindQ <= 1'b0;
                        errFullQ <= 1'b0;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (encLegal) begin
                            weQ    <= 1'b1;
                            wdataQ <= encWord;
                            if (topHit) begin
                                errFullQ <= 1'b1;
                            end
                        end else begin
                            errKindQ <= 1'b1;
                        end
                        if (inIf.in_last || (encLegal && topHit)) begin
                            stateQ <= StDrain;
                        end
                    end
                end
                StDrain: stateQ <= StDone;
                default: stateQ <= StIdle;
            endcase
        end
    end

    assign inIf.in_ready = (stateQ == StLoad);
    assign busy          = (stateQ == StLoad) || (stateQ == StDrain);
    assign done          = (stateQ == StDone);
    assign imem_we       = weQ;
    assign imem_addr     = ptrQ;
    assign imem_wdata    = wdataQ;
    assign err_kind      = errKindQ;
    assign err_full      = errFullQ;
    assign count         = countQ;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: directed sessions from the test plan
// followed by randomized sessions checked against a word-level reference model.
module tb_instr_stream_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'd0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err_kind;
    logic        err_full;
    logic [8:0]  count;

    instr_stream_encoder_if dIf ();

    instr_stream_encoder #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .inIf       (dIf),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err_kind   (err_kind),
        .err_full   (err_full),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        bit          last;
    } desc_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         expQ[$];
    int unsigned writeCycles[$];
    int unsigned cycleCnt = 0;
    int          nCompared = 0;
    int          nMismatch = 0;

    // Reference model state: next free address, words written, sticky flags.
    int unsigned mPtr;
    int unsigned mCount;
    bit          mErrKind;
    bit          mErrFull;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {legal, word} straight from the opcode map and field layouts.
    function automatic logic [32:0] refEncode(input desc_t d);
        case (d.kind)
            3'd0:    return {1'b1, 6'b100011, d.rs, d.rt, d.imm};
            3'd1:    return {1'b1, 6'b101011, d.rs, d.rt, d.imm};
            3'd2:    return {1'b1, 6'b000000, d.rs, d.rt, d.rd, 5'b00000, d.funct};
            3'd3:    return {1'b1, 6'b000001, d.rs, d.rt, d.imm};
            3'd4:    return {1'b1, 6'b000010, d.target};
            default: return 33'd0;
        endcase
    endfunction

    function automatic desc_t mk(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [5:0] funct,
                                 input logic [15:0] imm, input logic [25:0] target, input bit last);
        desc_t d;
        d.kind = kind; d.rs = rs; d.rt = rt; d.rd = rd; d.funct = funct;
        d.imm = imm; d.target = target; d.last = last;
        return d;
    endfunction

    function automatic desc_t randDesc(input bit last);
        desc_t d;
        d.kind   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        d.rs     = 5'($urandom);
        d.rt     = 5'($urandom);
        d.rd     = 5'($urandom);
        d.funct  = 6'($urandom);
        d.imm    = 16'($urandom);
        d.target = 26'($urandom);
        d.last   = last;
        return d;
    endfunction

    task automatic driveDesc(input desc_t d);
        dIf.in_kind   = d.kind;
        dIf.in_rs     = d.rs;
        dIf.in_rt     = d.rt;
        dIf.in_rd     = d.rd;
        dIf.in_funct  = d.funct;
        dIf.in_imm    = d.imm;
        dIf.in_target = d.target;
        dIf.in_last   = d.last;
    endtask

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            writeCycles.push_back(cycleCnt);
            if (expQ.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", imem_wdata, e.data);
            end
        end
    end

    task automatic issue(input desc_t d, input bit noGap, input bit pulse, output bit ended);
        int unsigned gap;
        int          tries;
        bit          acc;
        bit          rdy;
        logic [32:0] r;
        int unsigned wa;
        ended = 1'b0;
        @(negedge clk);
        start = 1'b0;
        gap = noGap ? 0 : $urandom_range(0, 2);
        if (gap != 0) begin
            dIf.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        driveDesc(d);
        dIf.in_valid = 1'b1;
        if (pulse) begin
            start     = 1'b1;
            base_addr = 8'($urandom);
        end
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 8) begin
            rdy = dIf.in_ready;
            @(posedge clk);
            if (rdy) acc = 1'b1;
            else begin
                tries++;
                @(negedge clk);
            end
        end
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            ended = 1'b1;
            return;
        end
        if (noGap) check("accept_first_cycle", 32'(tries), 32'd0);
        r  = refEncode(d);
        wa = mPtr;
        if (r[32]) begin
            expQ.push_back('{addr: wa[7:0], data: r[31:0]});
            mCount++;
            if (wa == 255) begin
                mErrFull = 1'b1;
                ended    = 1'b1;
            end else begin
                mPtr++;
            end
        end else begin
            mErrKind = 1'b1;
        end
        if (d.last) ended = 1'b1;
        #1;
        check("write_strobe", 32'(imem_we), 32'(r[32]));
        if (r[32]) check("write_addr_now", 32'(imem_addr), wa);
    endtask

    task automatic runSession(input logic [7:0] base, input desc_t ds[$], input bit noGap,
                              input bit pulseStart);
        bit ended;
        @(negedge clk);
        start        = 1'b1;
        base_addr    = base;
        dIf.in_valid = 1'b0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        mPtr     = base;
        mCount   = 0;
        mErrKind = 1'b0;
        mErrFull = 1'b0;
        writeCycles.delete();
        check("ready_after_start", 32'(dIf.in_ready), 32'd1);
        check("busy_after_start", 32'(busy), 32'd1);
        check("count_cleared", 32'(count), 32'd0);
        check("err_kind_cleared", 32'(err_kind), 32'd0);
        check("err_full_cleared", 32'(err_full), 32'd0);
        ended = 1'b0;
        foreach (ds[i]) begin
            if (!ended) issue(ds[i], noGap, pulseStart && (i == 1), ended);
        end
        start = 1'b0;
        if (!ended) check("session_ended", 32'd0, 32'd1);
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_not_done", 32'(done), 32'd0);
        check("drain_not_ready", 32'(dIf.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("done_flag", 32'(done), 32'd1);
        check("done_not_busy", 32'(busy), 32'd0);
        check("count_final", 32'(count), mCount);
        check("err_kind_final", 32'(err_kind), 32'(mErrKind));
        check("err_full_final", 32'(err_full), 32'(mErrFull));
        // A descriptor offered after the session must not be consumed.
        @(negedge clk);
        driveDesc(mk(3'd0, 5'd1, 5'd1, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0));
        dIf.in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("post_done_not_ready", 32'(dIf.in_ready), 32'd0);
        end
        @(negedge clk);
        dIf.in_valid = 1'b0;
        check("post_done_count", 32'(count), mCount);
        check("queue_drained", 32'(expQ.size()), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err_kind"}, 32'(err_kind), 32'd0);
        check({tag, "_err_full"}, 32'(err_full), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_in_ready"}, 32'(dIf.in_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        desc_t ds[$];
        bit    ended;
        dIf.in_valid = 1'b0;
        driveDesc(mk(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0));
        #12;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkResetState("idle");

        // Single LW.
        ds = '{mk(3'd0, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b1)};
        runSession(8'h10, ds, 1'b1, 1'b0);

        // Back-to-back mixed kinds with no bubbles.
        ds = '{mk(3'd2, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b0),
               mk(3'd1, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b0),
               mk(3'd3, 5'd0, 5'd7, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0),
               mk(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h40, 1'b1)};
        runSession(8'h20, ds, 1'b1, 1'b0);
        check("b2b_write_count", 32'(writeCycles.size()), 32'd4);
        if (writeCycles.size() == 4) begin
            check("b2b_no_bubble", writeCycles[3] - writeCycles[0], 32'd3);
        end

        // Illegal kind between two LWs.
        ds = '{mk(3'd0, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0),
               mk(3'd6, 5'd3, 5'd4, 5'd5, 6'd1, 16'h0002, 26'd9, 1'b0),
               mk(3'd0, 5'd6, 5'd7, 5'd0, 6'd0, 16'h0003, 26'd0, 1'b1)};
        runSession(8'h40, ds, 1'b0, 1'b0);

        // Top-of-memory termination; also restarts from DONE after an errored session.
        ds = '{mk(3'd0, 5'd1, 5'd1, 5'd0, 6'd0, 16'hAAAA, 26'd0, 1'b0),
               mk(3'd1, 5'd2, 5'd2, 5'd0, 6'd0, 16'hBBBB, 26'd0, 1'b0),
               mk(3'd3, 5'd3, 5'd3, 5'd0, 6'd0, 16'hCCCC, 26'd0, 1'b0)};
        runSession(8'hFE, ds, 1'b1, 1'b0);

        // start during LOAD must be ignored.
        ds = '{randDesc(1'b0), randDesc(1'b0), randDesc(1'b0), randDesc(1'b1)};
        ds[0].kind = 3'd0;
        ds[1].kind = 3'd2;
        runSession(8'h60, ds, 1'b0, 1'b1);

        // Asynchronous reset while a write is pending.
        @(negedge clk);
        start     = 1'b1;
        base_addr = 8'h30;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mPtr   = 8'h30;
        mCount = 0;
        issue(mk(3'd0, 5'd9, 5'd10, 5'd0, 6'd0, 16'h7777, 26'd0, 1'b0), 1'b1, 1'b0, ended);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetState("async_reset");
        expQ.delete();
        dIf.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized sessions.
        for (int s = 0; s < 30; s++) begin
            int unsigned n;
            logic [7:0]  base;
            n    = $urandom_range(1, 8);
            base = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom);
            ds.delete();
            for (int k = 0; k < int'(n); k++) ds.push_back(randDesc(k == int'(n) - 1));
            runSession(base, ds, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Encodes a handshaked stream of decoded instruction descriptors (kind plus register/immediate fields) into 32-bit MIPS instruction words. It writes them sequentially into instruction memory from a programmable base address. The opcode map is the inverse of the pipeline's control decoder: LW 6'b100011, SW 6'b101011, R-type 6'b000000, I-type ALU 6'b000001, J 6'b000010. It sits between the test/boot program source and the instruction memory write port, ahead of fetch.

## Interface
- ADDR_W, 8, instruction-memory word-address width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load session; honoured only in IDLE or DONE
- base_addr  in  ADDR_W  first word address, sampled on start
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready at a rising edge
- in_kind  in  3  0 LW, 1 SW, 2 RTYPE, 3 ITYPE, 4 JUMP, 5–7 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_funct  in  6  R-type funct
- in_imm  in  16  immediate
- in_target  in  26  jump target
- in_last  in  1  final descriptor of the session
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  state is LOAD or DRAIN
- done  out  1  state is DONE
- err_kind  out  1  sticky; an illegal kind was consumed
- err_full  out  1  sticky; the session ended because the top address was written
- count  out  ADDR_W+1  words written this session

## Operation
- States and transitions:
  - IDLE → LOAD on start: ptr←base_addr; count, err_kind and err_full cleared.
  - LOAD → DRAIN on accepting a last descriptor. A descriptor is last when in_last=1 or when it is written at ptr = 2^ADDR_W−1; the latter also sets err_full.
  - DRAIN → DONE after one cycle.
  - DONE → LOAD on start, with the same clearing as from IDLE.
  - start is ignored in LOAD and DRAIN.
- in_ready = (state == LOAD). It is combinational from state only and never depends on in_valid.
- Encoding:
  - LW/SW/ITYPE: {op, rs, rt, imm}.
  - RTYPE: {6'b0, rs, rt, rd, 5'b0, funct}; shamt is always zero.
  - JUMP: {6'b000010, target}.
- Illegal kind:
  - The descriptor is consumed but produces no write.
  - ptr and count are unchanged; err_kind sets.
  - in_last on an illegal descriptor still ends the session.
- Address wrap-around never occurs. Writing at the top address forces end of session as above.

## Timing
- Write latency is 1 cycle. A descriptor accepted at edge N gives imem_we=1 throughout cycle N+1, with imem_addr=ptr and the registered imem_wdata.
- ptr and count advance at edge N+1.
- Throughput is one word per cycle with back-to-back handshakes; there are no bubbles.
- Accepting the last descriptor at edge N:
  - DRAIN holds in cycle N+1 with the final write.
  - done=1 from cycle N+2.
  - in_ready=0 from cycle N+1.
- imem_we is never asserted outside the cycle following an accepted legal descriptor.
- Reset (asynchronous, any state) forces, immediately: IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, err_kind 0, err_full 0, count 0, ptr 0. Any pending write is dropped.
- A start pulse in DONE takes effect at that edge. in_ready rises the next cycle.

## Structure
- mips_isa_pkg (shared) holds:
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_J;
  - the instr_kind_t enum;
  - field-width localparams.
  The control decoder is migrated to this package.
- The state enum is local to the block.
- One combinational sub-module, instr_word_encode (kind and fields → word plus legal flag), is reused by the assembler testbench.

## Test plan
- start, base_addr=0x10; LW rs=2 rt=3 imm=0x0010, last → one write of 0x8C430010 at 0x10; done two cycles later; count=1.
- Back-to-back over 4 cycles:
  - RTYPE rs=1 rt=2 rd=3 funct=0x20 → 0x00221820
  - SW rs=4 rt=5 imm=0xFFFC → 0xAC85FFFC
  - ITYPE rs=0 rt=7 imm=5 → 0x04070005
  - JUMP target=0x40, last → 0x08000040

  Writes land at consecutive addresses with no idle cycle between them; count=4.
- Illegal kind 6 between two LWs → two writes at consecutive addresses; err_kind=1; count=2.
- base_addr=0xFE, three descriptors without in_last → writes at 0xFE and 0xFF only; the third is not accepted; err_full=1; done=1.
- rst_n asserted the cycle after an accept → imem_we drops asynchronously; all outputs return to reset values.
- start asserted during LOAD is ignored. start in DONE resets count and errors and re-enters LOAD.
